trap_priority_unit: RTL and testbench
=====================================

Name: trap_priority_unit

Overview:
- Successor to the single-class exception arbiter. Arbitrates E synchronous exception sources and I maskable interrupt sources into one trap request toward the CSR/trap controller.
- Exceptions are sticky until the request is acknowledged. Interrupts are level-sensitive and gated by per-source and global enables.
- The request is registered, held stable through a valid/ack handshake, and tracked against a trap-nesting depth counter.

Parameters:
- E, 10, number of exception sources (>=1)
- I, 3, number of interrupt sources (>=1)
- EXC_CODES, all 0, E x 32-bit cause codes, index 0 = highest priority
- IRQ_CODES, all 0, I x 32-bit cause codes, index 0 = highest priority; bit 31 is forced to 1 on output
- MAX_NEST, 2, maximum trap nesting depth (>=1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_exc  in  E  exception raise strobes
- i_irq  in  I  interrupt levels
- i_irq_en  in  I  per-interrupt enable (mie)
- i_global_ie  in  1  global interrupt enable (mstatus.MIE)
- i_trap_ack  in  1  trap controller accepts the current request
- i_trap_ret  in  1  trap return executed (mret)
- o_trap_valid  out  1  trap request pending
- o_trap_cause  out  32  cause for the current request
- o_trap_is_irq  out  1  current request is an interrupt
- o_depth  out  $clog2(MAX_NEST+1)  current nesting depth
- o_double_fault  out  1  one-cycle pulse on ack at full depth

Behaviour:
- Reset is asynchronous. While i_rst is high, all outputs are 0, the exception sticky register is 0, depth is 0, and the FSM is IDLE. Reset mid-request drops the request with no ack.
- Exception set: w_exc = r_exc | i_exc. r_exc <= w_exc each cycle, except in the ack cycle, where r_exc <= 0 and i_exc in that cycle is discarded (pipeline flush).
- Interrupt eligibility: w_irq = i_irq & i_irq_en, qualified by i_global_ie and depth == 0.
- Selection: any w_exc bit wins over any interrupt. Within a class, the lowest index wins.
- FSM states: IDLE, REQ.
- IDLE: if any candidate exists, register cause, is_irq and valid=1, then go to REQ. Latency is 1 cycle from input to o_trap_valid.
- REQ: o_trap_valid is held at 1.
  - Cause is held stable unless the latched request is an interrupt and an exception becomes pending. In that case cause and is_irq switch to the exception on the next cycle.
  - An interrupt deasserting while in REQ does not withdraw the request.
  - A lower-index exception arriving while an exception is latched does not change the cause.
- Ack: i_trap_ack is sampled only in REQ and ignored in IDLE. On ack:
  - o_trap_valid = 0 next cycle; FSM goes to IDLE.
  - depth saturating-increments.
  - If depth == MAX_NEST at the ack, o_double_fault pulses for 1 cycle and depth stays at MAX_NEST.
  - No new request is raised in the cycle after ack (one-cycle bubble).
- Trap return: i_trap_ret decrements depth with a floor of 0, and is honoured in any state.
  - If ack and ret occur in the same cycle, depth is unchanged, except that a ret with depth 0 plus an ack gives depth 1.
- Nesting: exceptions may raise requests at any depth. Interrupts only raise requests at depth 0.
- Cause width is fixed at 32. For interrupts, o_trap_cause = {1'b1, IRQ_CODES[k][30:0]}.

Decomposition:
- Shared package trap_pkg: CAUSE_W=32, IRQ_BIT=31, the FSM state enum, and default RISC-V cause constants (illegal instruction, ecall, load/store misaligned, MTI/MEI/MSI).
- Sub-module prio_enc #(N): returns the lowest-set index and a valid flag. It is instantiated twice, once for exceptions and once for interrupts.

Test Plan:
- E=10, I=3, codes = index values. Pulse i_exc=10'b0000100100 at cycle 5 -> o_trap_valid=1 at cycle 6, cause=2; ack at cycle 8 -> valid=0 at cycle 9, depth=1, r_exc cleared (index 5 not re-raised).
- i_irq=3'b110, en=3'b111, global_ie=1, depth 0 -> cause=32'h8000_0001, is_irq=1. Drop i_irq while in REQ -> request held until ack.
- Interrupt latched in REQ, then i_exc[7] pulse -> next cycle cause=7, is_irq=0. Ack -> depth=1. Assert i_irq -> no request until i_trap_ret, then the interrupt request reappears 1 cycle after depth returns to 0.
- MAX_NEST=2: three exception/ack pairs without ret -> o_double_fault pulses exactly once on the third ack and depth stays at 2. Two rets -> depth 0; a further ret -> depth stays 0.
- Exception pulse coincident with ack -> discarded, no new request. Assert i_rst asynchronously mid-REQ -> all outputs 0 immediately, without waiting for a clock edge.
- Global_ie=0 or i_irq_en=0 with i_irq asserted -> no request for 20 cycles. An exception during that window is still reported.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the trap priority unit: cause width, the interrupt
// flag bit position, the arbiter FSM state type, the registered request
// record and the default RISC-V machine-mode cause codes.
package trap_pkg;

  localparam int CAUSE_W = 32;
  localparam int IRQ_BIT = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // Request as presented to the trap controller.
  typedef struct packed {
    logic [CAUSE_W-1:0] cause;
    logic               is_irq;
  } trap_req_t;

  // Default synchronous exception causes.
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL_INSTR    = 32'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_STORE_MISALIGNED = 32'd6;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M          = 32'd11;

  // Default interrupt causes (interrupt flag is applied by irq_cause()).
  localparam logic [CAUSE_W-1:0] CAUSE_MSI = 32'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_MTI = 32'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_MEI = 32'd11;

  // Interrupt causes always carry the interrupt flag in the MSB.
  function automatic logic [CAUSE_W-1:0] irq_cause(input logic [CAUSE_W-1:0] code);
    irq_cause          = code;
    irq_cause[IRQ_BIT] = 1'b1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req and whether
// any bit is set.
//   req   in  N     request vector, bit 0 = highest priority
//   idx   out IW    index of lowest set bit (0 when none set)
//   valid out 1     any bit of req set
module prio_enc #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/trap_priority_unit.sv
// Arbitrates E sticky synchronous exceptions and I level-sensitive maskable
// interrupts into one registered trap request with a valid/ack handshake,
// and tracks trap nesting depth.
//   i_clk          in  1      clock
//   i_rst          in  1      asynchronous active-high reset
//   i_exc          in  E      exception raise strobes
//   i_irq          in  I      interrupt levels
//   i_irq_en       in  I      per-interrupt enables
//   i_global_ie    in  1      global interrupt enable
//   i_trap_ack     in  1      controller accepts current request
//   i_trap_ret     in  1      trap return executed
//   o_trap_valid   out 1      request pending
//   o_trap_cause   out 32     cause of current request
//   o_trap_is_irq  out 1      current request is an interrupt
//   o_depth        out DW     current nesting depth
//   o_double_fault out 1      pulse after an ack taken at full depth
module trap_priority_unit
  import trap_pkg::*;
#(
  parameter  int                             E         = 10,
  parameter  int                             I         = 3,
  parameter  logic [E-1:0][CAUSE_W-1:0]      EXC_CODES = '0,
  parameter  logic [I-1:0][CAUSE_W-1:0]      IRQ_CODES = '0,
  parameter  int                             MAX_NEST  = 2,
  localparam int                             DW        = $clog2(MAX_NEST + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [E-1:0]       i_exc,
  input  logic [I-1:0]       i_irq,
  input  logic [I-1:0]       i_irq_en,
  input  logic               i_global_ie,
  input  logic               i_trap_ack,
  input  logic               i_trap_ret,
  output logic               o_trap_valid,
  output logic [CAUSE_W-1:0] o_trap_cause,
  output logic               o_trap_is_irq,
  output logic [DW-1:0]      o_depth,
  output logic               o_double_fault
);

  localparam int EIW = (E > 1) ? $clog2(E) : 1;
  localparam int IIW = (I > 1) ? $clog2(I) : 1;

  state_t             state, state_nx;
  trap_req_t          req_q, req_nx, cand;
  logic [E-1:0]       r_exc, w_exc;
  logic [I-1:0]       w_irq;
  logic [EIW-1:0]     exc_idx;
  logic [IIW-1:0]     irq_idx;
  logic               exc_any, irq_any;
  logic [CAUSE_W-1:0] exc_code, irq_code;
  logic [DW-1:0]      depth, depth_nx;
  logic               bubble, r_dfault;
  logic               ack, at_max, irq_ok;

  assign ack    = (state == ST_REQ) && i_trap_ack;
  assign at_max = (depth == DW'(MAX_NEST));
  assign w_exc  = r_exc | i_exc;
  // Interrupts are only taken when not already inside a trap.
  assign irq_ok = i_global_ie && (depth == '0);
  assign w_irq  = i_irq & i_irq_en & {I{irq_ok}};

  prio_enc #(.N(E)) u_exc_enc (.req(w_exc), .idx(exc_idx), .valid(exc_any));
  prio_enc #(.N(I)) u_irq_enc (.req(w_irq), .idx(irq_idx), .valid(irq_any));

  // Cause lookup by explicit compare so a non-power-of-two source count
  // never indexes past the code table.
  always_comb begin
    exc_code = '0;
    for (int k = 0; k < E; k++) begin
      if (exc_idx == EIW'(k)) exc_code = EXC_CODES[k];
    end
  end

  always_comb begin
    irq_code = '0;
    for (int k = 0; k < I; k++) begin
      if (irq_idx == IIW'(k)) irq_code = irq_cause(IRQ_CODES[k]);
    end
  end

  // Any pending exception outranks every interrupt.
  always_comb begin
    cand.cause  = exc_any ? exc_code : irq_code;
    cand.is_irq = !exc_any;
  end

  always_comb begin
    state_nx = state;
    req_nx   = req_q;
    case (state)
      ST_IDLE: begin
        // bubble blocks a new request in the cycle right after an ack.
        if (!bubble && (exc_any || irq_any)) begin
          state_nx = ST_REQ;
          req_nx   = cand;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_nx = ST_IDLE;
          req_nx   = '0;
        end else if (req_q.is_irq && exc_any) begin
          // A latched interrupt is preempted by a newly pending exception;
          // a latched exception is never replaced.
          req_nx.cause  = exc_code;
          req_nx.is_irq = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Ack and ret together cancel, except that from depth 0 the ret has
  // nothing to undo so the ack still takes effect.
  always_comb begin
    depth_nx = depth;
    case ({ack, i_trap_ret})
      2'b10:   depth_nx = at_max ? depth : depth + DW'(1);
      2'b01:   depth_nx = (depth == '0) ? depth : depth - DW'(1);
      2'b11:   depth_nx = (depth == '0) ? DW'(1) : depth;
      default: depth_nx = depth;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      req_q <= '0;
    end else begin
      state <= state_nx;
      req_q <= req_nx;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_exc    <= '0;
      depth    <= '0;
      bubble   <= 1'b0;
      r_dfault <= 1'b0;
    end else begin
      // Exceptions raised in the ack cycle belong to the flushed pipeline.
      r_exc    <= ack ? '0 : w_exc;
      depth    <= depth_nx;
      bubble   <= ack;
      r_dfault <= ack && at_max;
    end
  end

  assign o_trap_valid   = (state == ST_REQ);
  assign o_trap_cause   = req_q.cause;
  assign o_trap_is_irq  = req_q.is_irq;
  assign o_depth        = depth;
  assign o_double_fault = r_dfault;

endmodule

// File: tb/tb_trap_priority_unit.sv
// Randomized plus directed bench for trap_priority_unit with a cycle-level
// reference model feeding an expectation queue drained by a monitor.
module tb_trap_priority_unit;

  localparam int E = 10;
  localparam int I = 3;
  localparam int MAX_NEST = 2;
  localparam int DW = 2;
  localparam logic [E-1:0][31:0] EC = {32'd9, 32'd8, 32'd7, 32'd6, 32'd5,
                                       32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
  localparam logic [I-1:0][31:0] IC = {32'd2, 32'd1, 32'd0};

  logic clk = 1'b0, rst = 1'b1;
  logic [E-1:0] exc = '0;
  logic [I-1:0] irq = '0, irq_en = '0;
  logic gie = 1'b0, ack = 1'b0, ret = 1'b0;
  logic valid, is_irq, df;
  logic [31:0] cause;
  logic [DW-1:0] depth;

  trap_priority_unit #(.E(E), .I(I), .EXC_CODES(EC), .IRQ_CODES(IC), .MAX_NEST(MAX_NEST)) dut (
    .i_clk(clk), .i_rst(rst), .i_exc(exc), .i_irq(irq), .i_irq_en(irq_en),
    .i_global_ie(gie), .i_trap_ack(ack), .i_trap_ret(ret),
    .o_trap_valid(valid), .o_trap_cause(cause), .o_trap_is_irq(is_irq),
    .o_depth(depth), .o_double_fault(df)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; bit [31:0] c; bit irq; int d; bit df;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, df_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: pending set, latched request and depth as plain values.
  bit m_v, m_irq, m_bub;
  int m_idx, m_d;
  logic [E-1:0] m_exc;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_v = 0; m_irq = 0; m_bub = 0; m_idx = 0; m_d = 0; m_exc = '0;
      q.delete();
    end else begin
      automatic logic [E-1:0] pend = m_exc | exc;
      automatic logic [I-1:0] elig = (gie && m_d == 0) ? (irq & irq_en) : '0;
      automatic bit a = m_v && ack;
      automatic bit dfn = a && (m_d == MAX_NEST);
      automatic exp_t e;
      // A return is applied first, then the ack re-enters (capped).
      if (ret && m_d > 0) m_d--;
      if (a && m_d < MAX_NEST) m_d++;
      if (a) begin
        m_v = 0; m_exc = '0;
      end else begin
        if (m_v) begin
          if (m_irq && pend != 0) begin m_irq = 0; m_idx = lowest(32'(pend), E); end
        end else if (!m_bub && pend != 0) begin
          m_v = 1; m_irq = 0; m_idx = lowest(32'(pend), E);
        end else if (!m_bub && elig != 0) begin
          m_v = 1; m_irq = 1; m_idx = lowest(32'(elig), I);
        end
        m_exc = pend;
      end
      m_bub = a;
      e.v = m_v; e.irq = m_irq; e.d = m_d; e.df = dfn;
      e.c = m_irq ? (32'h8000_0000 | 32'(m_idx)) : 32'(m_idx);
      q.push_back(e);
    end
  end

  // Monitor: compares DUT outputs against the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (df === 1'b1) df_seen++;
    if (q.size() > 0) begin
      automatic exp_t e = q.pop_front();
      chk("valid", 32'(valid), 32'(e.v));
      chk("depth", 32'(depth), 32'(e.d));
      chk("double_fault", 32'(df), 32'(e.df));
      if (e.v) begin
        chk("cause", cause, e.c);
        chk("is_irq", 32'(is_irq), 32'(e.irq));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_exc(input logic [E-1:0] v);
    exc = v; tick(); exc = '0;
  endtask
  task automatic ack1();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask
  task automatic ret1();
    ret = 1'b1; tick(); ret = 1'b0;
  endtask

  initial begin
    int d0, seen;
    tick(3);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_cause", cause, 0);
    chk("rst_depth", 32'(depth), 0);
    rst = 1'b0;

    // Two exceptions: lowest index wins, the other is flushed by the ack.
    tick(2);
    pulse_exc(10'b0000100100);
    chk("t1_cause", cause, 2);
    tick(1);
    ack1();
    tick(3);
    chk("t1_depth", 32'(depth), 1);
    chk("t1_no_rerise", 32'(valid), 0);
    ret1(); tick(2);

    // Interrupt request held after the level drops.
    irq = 3'b110; irq_en = 3'b111; gie = 1'b1;
    tick(2);
    chk("t2_cause", cause, 32'h8000_0001);
    irq = '0; tick(3);
    chk("t2_held", 32'(valid), 1);
    ack1(); ret1(); tick(2);

    // Exception preempts a latched interrupt; interrupts blocked at depth 1.
    irq = 3'b001; tick(2);
    pulse_exc(10'b0010000000);
    chk("t3_cause", cause, 7);
    chk("t3_is_irq", 32'(is_irq), 0);
    ack1(); tick(5);
    chk("t3_blocked", 32'(valid), 0);
    ret1(); tick(3);
    chk("t3_irq_back", cause, 32'h8000_0000);
    ack1(); irq = '0; ret1(); tick(2);

    // Nesting saturation and double fault.
    d0 = df_seen;
    for (int k = 0; k < 3; k++) begin
      pulse_exc(10'(1) << k); tick(1); ack1(); tick(1);
    end
    chk("t4_df_count", 32'(df_seen - d0), 1);
    chk("t4_depth_sat", 32'(depth), 2);
    ret1(); ret1();
    chk("t4_depth0", 32'(depth), 0);
    ret1();
    chk("t4_depth_floor", 32'(depth), 0);

    // Exception coincident with ack is discarded; async reset mid-request.
    pulse_exc(10'b0000001000); tick(1);
    exc = 10'b0000010000; ack = 1'b1; tick(); exc = '0; ack = 1'b0;
    tick(3);
    chk("t5_discard", 32'(valid), 0);
    pulse_exc(10'b0000000010); tick(1);
    @(posedge clk); #2 rst = 1'b1; #1;
    chk("t5_arst_valid", 32'(valid), 0);
    chk("t5_arst_cause", cause, 0);
    chk("t5_arst_irq", 32'(is_irq), 0);
    chk("t5_arst_depth", 32'(depth), 0);
    chk("t5_arst_df", 32'(df), 0);
    tick(2); rst = 1'b0; tick(1);

    // Masked interrupts stay quiet; exceptions still get through.
    gie = 1'b0; irq = 3'b111; irq_en = 3'b111; seen = 0;
    for (int k = 0; k < 20; k++) begin tick(1); if (valid) seen++; end
    chk("t6_gie_quiet", 32'(seen), 0);
    pulse_exc(10'b1000000000);
    chk("t6_exc_cause", cause, 9);
    ack1(); ret1();
    gie = 1'b1; irq_en = '0; seen = 0;
    for (int k = 0; k < 20; k++) begin tick(1); if (valid) seen++; end
    chk("t6_en_quiet", 32'(seen), 0);
    irq = '0; tick(2);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      exc    = ($urandom_range(0, 7) == 0) ? E'($urandom) : '0;
      irq    = I'($urandom);
      irq_en = I'($urandom);
      gie    = ($urandom_range(0, 3) != 0);
      ack    = ($urandom_range(0, 2) == 0);
      ret    = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    exc = '0; irq = '0; ack = 1'b0; ret = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
